// File: rtl/seq_accum_alu_if.sv
// Operand/result bundle between the input logic (master) and the accumulator ALU (slave).
interface seq_accum_alu_if #(
  parameter int WIDTH = 4
);
  localparam int ACC_W = 2 * WIDTH;

  logic             Start;
  logic [WIDTH-1:0] Data;
  logic [2:0]       Function;
  logic             Busy;
  logic             Done;
  logic [ACC_W-1:0] ALUout;
  logic             Overflow;

  modport master (
    output Start, Data, Function,
    input  Busy, Done, ALUout, Overflow
  );

  modport slave (
    input  Start, Data, Function,
    output Busy, Done, ALUout, Overflow
  );
endinterface

// File: rtl/seq_accum_alu.sv
// Accumulator ALU: Data combined with the low half of its own 2*WIDTH result register,
// single-cycle ops plus a WIDTH-step shift-add multiply behind a Start/Busy/Done handshake.
//
//   state | meaning
//   IDLE  | waiting for Start; single-cycle ops complete on the Start edge
//   MUL   | one shift-add step per cycle, WIDTH steps, result written on the last
module seq_accum_alu #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset_b,
  seq_accum_alu_if.slave   bus
);
  localparam int ACC_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [ACC_W-1:0] ACC_W_V  = ACC_W'(ACC_W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_ACC = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] alu_out_q, alu_out_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] a_ext, b_ext, prod_step;
  logic [ACC_W:0]   acc_sum, sub_diff;

  assign a_ext     = ACC_W'(bus.Data);
  assign b_ext     = ACC_W'(alu_out_q[WIDTH-1:0]);
  assign acc_sum   = {1'b0, alu_out_q} + {1'b0, a_ext};
  assign sub_diff  = {1'b0, b_ext} - {1'b0, a_ext};
  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_out_d = alu_out_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    mplier_d  = mplier_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (bus.Function == OP_MUL) begin
            // Operands are latched here so later Data/ALUout changes cannot disturb the product.
            state_d  = MUL;
            cnt_d    = '0;
            mcand_d  = a_ext;
            mplier_d = alu_out_q[WIDTH-1:0];
            prod_d   = '0;
          end else begin
            done_d = 1'b1;
            case (bus.Function)
              OP_ADD: alu_out_d = a_ext + b_ext;
              OP_SHL: alu_out_d = (a_ext >= ACC_W_V) ? '0 : (b_ext << bus.Data);
              OP_ACC: begin
                alu_out_d = acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) ovf_d = 1'b1;
              end
              OP_XOR: alu_out_d = a_ext ^ b_ext;
              OP_SUB: begin
                alu_out_d = sub_diff[ACC_W-1:0];
                if (sub_diff[ACC_W]) ovf_d = 1'b1;
              end
              OP_CLR: begin
                alu_out_d = '0;
                ovf_d     = 1'b0;
              end
              default: alu_out_d = alu_out_q;
            endcase
          end
        end
      end
      MUL: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          alu_out_d = prod_step;
          done_d    = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alu_out_q <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      mplier_q  <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_out_q <= alu_out_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      mplier_q  <= mplier_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.Busy     = (state_q == MUL);
  assign bus.Done     = done_q;
  assign bus.ALUout   = alu_out_q;
  assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_seq_accum_alu.sv
// Directed bench for seq_accum_alu (WIDTH=4): chained op table plus hand-written
// sequences for mid-multiply Start, Start in the Done cycle and reset during multiply.
module tb_seq_accum_alu;
  logic Clock = 1'b0;
  logic Reset_b;

  seq_accum_alu_if #(.WIDTH(4)) bus ();

  seq_accum_alu #(.WIDTH(4)) dut (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0] f;
    logic [3:0] d;
    logic [7:0] exp_out;
    logic       exp_ovf;
    int         exp_busy;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [3:0] d, input logic [7:0] exp_out,
                        input logic exp_ovf, input int exp_busy, input string tag);
    int busy_n;
    @(negedge Clock);
    bus.Start = 1'b1; bus.Function = f; bus.Data = d;
    @(negedge Clock);
    bus.Start = 1'b0; bus.Function = ~f; bus.Data = ~d;
    busy_n = 0;
    for (int k = 0; k < 20 && !bus.Done; k++) begin
      if (bus.Busy) busy_n++;
      @(negedge Clock);
    end
    check({tag, " done"},     bus.Done, 1);
    check({tag, " busy_cyc"}, busy_n, exp_busy);
    check({tag, " busy_lo"},  bus.Busy, 0);
    check({tag, " aluout"},   bus.ALUout, exp_out);
    check({tag, " ovf"},      bus.Overflow, exp_ovf);
    @(negedge Clock);
    check({tag, " done_pulse"}, bus.Done, 0);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 4'd5,  8'h05, 1'b0, 0};
    vecs[1]  = '{3'b001, 4'd3,  8'h0F, 1'b0, 4};
    vecs[2]  = '{3'b111, 4'd0,  8'h00, 1'b0, 0};
    vecs[3]  = '{3'b000, 4'd3,  8'h03, 1'b0, 0};
    vecs[4]  = '{3'b010, 4'd2,  8'h0C, 1'b0, 0};
    vecs[5]  = '{3'b111, 4'd0,  8'h00, 1'b0, 0};
    vecs[6]  = '{3'b000, 4'd3,  8'h03, 1'b0, 0};
    vecs[7]  = '{3'b010, 4'd9,  8'h00, 1'b0, 0};
    vecs[8]  = '{3'b000, 4'd15, 8'h0F, 1'b0, 0};
    vecs[9]  = '{3'b010, 4'd4,  8'hF0, 1'b0, 0};
    vecs[10] = '{3'b100, 4'd14, 8'hFE, 1'b0, 0};
    vecs[11] = '{3'b100, 4'd3,  8'h01, 1'b1, 0};
    vecs[12] = '{3'b111, 4'd0,  8'h00, 1'b0, 0};
    vecs[13] = '{3'b000, 4'd2,  8'h02, 1'b0, 0};
    vecs[14] = '{3'b110, 4'd5,  8'hFD, 1'b1, 0};
    vecs[15] = '{3'b000, 4'd0,  8'h0D, 1'b1, 0};
    vecs[16] = '{3'b101, 4'd6,  8'h0B, 1'b1, 0};
    vecs[17] = '{3'b011, 4'd7,  8'h0B, 1'b1, 0};
    vecs[18] = '{3'b001, 4'd7,  8'h4D, 1'b1, 4};
    vecs[19] = '{3'b001, 4'd15, 8'hC3, 1'b1, 4};
    vecs[20] = '{3'b110, 4'd2,  8'h01, 1'b1, 0};
    vecs[21] = '{3'b111, 4'd0,  8'h00, 1'b0, 0};
    vecs[22] = '{3'b110, 4'd0,  8'h00, 1'b0, 0};
    vecs[23] = '{3'b100, 4'd15, 8'h0F, 1'b0, 0};

    bus.Start = 1'b0; bus.Function = 3'b000; bus.Data = 4'd0;
    Reset_b = 1'b1;
    repeat (2) @(negedge Clock);
    Reset_b = 1'b0;
    check("rst aluout", bus.ALUout, 0);
    check("rst busy",   bus.Busy, 0);
    check("rst done",   bus.Done, 0);
    check("rst ovf",    bus.Overflow, 0);

    for (int i = 0; i < NVEC; i++)
      run_op(vecs[i].f, vecs[i].d, vecs[i].exp_out, vecs[i].exp_ovf, vecs[i].exp_busy,
             $sformatf("vec%0d", i));

    // Start during MUL is dropped; Start in the Done cycle is taken.
    run_op(3'b111, 4'd0, 8'h00, 1'b0, 0, "pre_clr");
    run_op(3'b000, 4'd5, 8'h05, 1'b0, 0, "pre_add");
    @(negedge Clock);
    bus.Start = 1'b1; bus.Function = 3'b001; bus.Data = 4'd3;
    @(negedge Clock);
    bus.Start = 1'b0;
    check("mid busy1", bus.Busy, 1);
    check("mid done1", bus.Done, 0);
    check("mid hide1", bus.ALUout, 8'h05);
    @(negedge Clock);
    bus.Start = 1'b1; bus.Function = 3'b000; bus.Data = 4'd9;
    check("mid busy2", bus.Busy, 1);
    @(negedge Clock);
    bus.Start = 1'b0;
    check("mid busy3", bus.Busy, 1);
    check("mid hide3", bus.ALUout, 8'h05);
    @(negedge Clock);
    check("mid busy4", bus.Busy, 1);
    check("mid done4", bus.Done, 0);
    @(negedge Clock);
    check("mid done",   bus.Done, 1);
    check("mid busy5",  bus.Busy, 0);
    check("mid result", bus.ALUout, 8'h0F);
    bus.Start = 1'b1; bus.Function = 3'b000; bus.Data = 4'd1;
    @(negedge Clock);
    bus.Start = 1'b0;
    check("dcyc done",   bus.Done, 1);
    check("dcyc result", bus.ALUout, 8'h10);
    @(negedge Clock);
    check("dcyc pulse",  bus.Done, 0);
    check("dcyc noqueue", bus.ALUout, 8'h10);

    // Reset on the second Busy cycle abandons the multiply.
    run_op(3'b000, 4'd3, 8'h03, 1'b0, 0, "pre_add3");
    run_op(3'b110, 4'd5, 8'hFE, 1'b1, 0, "pre_sub");
    @(negedge Clock);
    bus.Start = 1'b1; bus.Function = 3'b001; bus.Data = 4'd3;
    @(negedge Clock);
    bus.Start = 1'b0;
    check("rmul busy1", bus.Busy, 1);
    @(negedge Clock);
    check("rmul busy2", bus.Busy, 1);
    Reset_b = 1'b1;
    @(negedge Clock);
    Reset_b = 1'b0;
    check("rmul aluout", bus.ALUout, 0);
    check("rmul busy",   bus.Busy, 0);
    check("rmul done",   bus.Done, 0);
    check("rmul ovf",    bus.Overflow, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      check($sformatf("rmul nodone%0d", k), bus.Done, 0);
    end
    check("rmul aluout_late", bus.ALUout, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
